// File: rtl/ctrl_pipe_decoder_pkg.sv
// Shared types and constants for the fetch->execute control decoder.
// Instruction layout (IW=9): [8:6] opcode, [5:4] funct, [5:1] immediate,
// register fields for three-register classes: [3:2] = A / destination, [1:0] = B.
package ctrl_pipe_decoder_pkg;

  localparam int unsigned IW   = 9;
  localparam int unsigned OPW  = 4;
  localparam int unsigned RAW  = 4;
  localparam int unsigned IMMW = 5;

  typedef enum logic [2:0] {
    OP_R    = 3'b000,
    OP_LB   = 3'b001,
    OP_SB   = 3'b010,
    OP_ADDI = 3'b011,
    OP_BR   = 3'b100,
    OP_MOV  = 3'b101,
    OP_ALU2 = 3'b110,
    OP_ALU3 = 3'b111
  } opcode_t;

  // R-class funct values
  localparam logic [1:0] FN_ADD   = 2'b00;
  localparam logic [1:0] FN_SUB   = 2'b01;
  localparam logic [1:0] FN_LOAD  = 2'b10;
  localparam logic [1:0] FN_STORE = 2'b11;

  localparam logic [OPW-1:0] ALU_ADD  = 4'h0;
  localparam logic [OPW-1:0] ALU_SUB  = 4'h1;
  localparam logic [OPW-1:0] ALU_AND  = 4'h2;
  localparam logic [OPW-1:0] ALU_OR   = 4'h3;
  localparam logic [OPW-1:0] ALU_XOR  = 4'h4;
  localparam logic [OPW-1:0] ALU_SLT  = 4'h5;
  localparam logic [OPW-1:0] ALU_SLL  = 4'h6;
  localparam logic [OPW-1:0] ALU_SRL  = 4'h7;
  localparam logic [OPW-1:0] ALU_MUL  = 4'h8;
  localparam logic [OPW-1:0] ALU_BEQ  = 4'h9;
  localparam logic [OPW-1:0] ALU_BNE  = 4'hA;
  localparam logic [OPW-1:0] ALU_BLT  = 4'hB;
  localparam logic [OPW-1:0] ALU_BLE  = 4'hC;
  localparam logic [OPW-1:0] ALU_PASS = 4'hF;

  typedef struct packed {
    logic            valid;
    logic [OPW-1:0]  aluop;
    logic            regwr;
    logic            memwr;
    logic            memtoreg;
    logic            alusrc;
    logic            memsrc;
    logic            branch;
    logic [RAW-1:0]  rega;
    logic [RAW-1:0]  regb;
    logic [RAW-1:0]  wraddr;
    logic [IMMW-1:0] immed;
  } ctrl_word_t;

  // Empty ID/EX slot; also the reset value of the ID/EX register
  localparam ctrl_word_t BUBBLE = '{
    valid:    1'b0,
    aluop:    ALU_PASS,
    regwr:    1'b0,
    memwr:    1'b0,
    memtoreg: 1'b0,
    alusrc:   1'b0,
    memsrc:   1'b0,
    branch:   1'b0,
    rega:     RAW'(0),
    regb:     RAW'(1),
    wraddr:   RAW'(0),
    immed:    IMMW'(0)
  };

endpackage

// File: rtl/ctrl_pipe_decoder_if.sv
// Fetch/execute-side bundle of the control decoder.
// master: fetch/EX stage (drives in_valid, instr, br_taken).
// slave : decoder (drives in_ready, flush and the ex_* control word).
interface ctrl_pipe_decoder_if;
  import ctrl_pipe_decoder_pkg::*;

  logic            in_valid;
  logic [IW-1:0]   instr;
  logic            in_ready;
  logic            br_taken;
  logic            flush;
  logic            ex_valid;
  logic [OPW-1:0]  ex_aluop;
  logic            ex_regwr;
  logic            ex_memwr;
  logic            ex_memtoreg;
  logic            ex_alusrc;
  logic            ex_memsrc;
  logic            ex_branch;
  logic [RAW-1:0]  ex_rega;
  logic [RAW-1:0]  ex_regb;
  logic [RAW-1:0]  ex_wraddr;
  logic [IMMW-1:0] ex_immed;

  modport master (
    output in_valid, instr, br_taken,
    input  in_ready, flush, ex_valid, ex_aluop, ex_regwr, ex_memwr, ex_memtoreg,
           ex_alusrc, ex_memsrc, ex_branch, ex_rega, ex_regb, ex_wraddr, ex_immed
  );

  modport slave (
    input  in_valid, instr, br_taken,
    output in_ready, flush, ex_valid, ex_aluop, ex_regwr, ex_memwr, ex_memtoreg,
           ex_alusrc, ex_memsrc, ex_branch, ex_rega, ex_regb, ex_wraddr, ex_immed
  );

endinterface

// File: rtl/ctrl_pipe_decoder_decode.sv
// Pure combinational instruction decoder.
// Ports: instr_i      instruction word
//        word_c_o     decoded control word (valid=1 unless illegal)
//        rd_a_c_o     instruction reads register rega
//        rd_b_c_o     instruction reads register regb
//        illegal_c_o  encoding 111/11
module ctrl_pipe_decoder_decode
  import ctrl_pipe_decoder_pkg::*;
(
  input  logic [IW-1:0] instr_i,
  output ctrl_word_t    word_c_o,
  output logic          rd_a_c_o,
  output logic          rd_b_c_o,
  output logic          illegal_c_o
);

  opcode_t        op;
  logic [1:0]     funct;
  logic [RAW-1:0] fld_a;
  logic [RAW-1:0] fld_b;

  assign op    = opcode_t'(instr_i[IW-1 -: 3]);
  assign funct = instr_i[IW-4 -: 2];
  assign fld_a = RAW'(instr_i[3:2]);
  assign fld_b = RAW'(instr_i[1:0]);

  // Per-class control fields on top of the bubble defaults
  always_comb begin
    word_c_o       = BUBBLE;
    word_c_o.valid = 1'b1;
    word_c_o.immed = instr_i[IMMW:1];
    rd_a_c_o       = 1'b0;
    rd_b_c_o       = 1'b0;
    illegal_c_o    = 1'b0;
    unique case (op)
      OP_R: begin
        unique case (funct)
          FN_ADD, FN_SUB: begin
            word_c_o.aluop  = (funct == FN_ADD) ? ALU_ADD : ALU_SUB;
            word_c_o.regwr  = 1'b1;
            word_c_o.rega   = fld_a;
            word_c_o.regb   = fld_b;
            word_c_o.wraddr = fld_a;
            rd_a_c_o        = 1'b1;
            rd_b_c_o        = 1'b1;
          end
          FN_LOAD: begin
            word_c_o.regwr    = 1'b1;
            word_c_o.memtoreg = 1'b1;
            word_c_o.rega     = fld_b;
            word_c_o.wraddr   = fld_a;
            rd_a_c_o          = 1'b1;
          end
          FN_STORE: begin
            // Store data comes from the register named in the destination field
            word_c_o.memwr  = 1'b1;
            word_c_o.rega   = fld_b;
            word_c_o.regb   = fld_a;
            word_c_o.wraddr = fld_a;
            rd_a_c_o        = 1'b1;
            rd_b_c_o        = 1'b1;
          end
        endcase
      end
      OP_LB: begin
        word_c_o.memsrc   = 1'b1;
        word_c_o.memtoreg = 1'b1;
        word_c_o.regwr    = 1'b1;
        word_c_o.wraddr   = RAW'(instr_i[0]);
      end
      OP_SB: begin
        word_c_o.memsrc = 1'b1;
        word_c_o.memwr  = 1'b1;
        word_c_o.rega   = RAW'(instr_i[0]);
        rd_a_c_o        = 1'b1;
      end
      OP_ADDI: begin
        word_c_o.aluop  = ALU_ADD;
        word_c_o.alusrc = 1'b1;
        word_c_o.regwr  = 1'b1;
        word_c_o.wraddr = RAW'(1);
        rd_a_c_o        = 1'b1;
      end
      OP_BR: begin
        word_c_o.branch = 1'b1;
        rd_a_c_o        = 1'b1;
        rd_b_c_o        = 1'b1;
        unique case (funct)
          2'b00: word_c_o.aluop = ALU_BEQ;
          2'b01: word_c_o.aluop = ALU_BNE;
          2'b10: word_c_o.aluop = ALU_BLT;
          2'b11: word_c_o.aluop = ALU_BLE;
        endcase
      end
      OP_MOV: begin
        word_c_o.regwr  = 1'b1;
        word_c_o.rega   = RAW'(instr_i[4:1]);
        word_c_o.wraddr = RAW'(instr_i[5]);
        rd_a_c_o        = 1'b1;
      end
      OP_ALU2, OP_ALU3: begin
        word_c_o.regwr  = 1'b1;
        word_c_o.rega   = fld_a;
        word_c_o.regb   = fld_b;
        word_c_o.wraddr = fld_a;
        rd_a_c_o        = 1'b1;
        rd_b_c_o        = 1'b1;
        if (op == OP_ALU2) begin
          unique case (funct)
            2'b00: word_c_o.aluop = ALU_AND;
            2'b01: word_c_o.aluop = ALU_OR;
            2'b10: word_c_o.aluop = ALU_XOR;
            2'b11: word_c_o.aluop = ALU_SLT;
          endcase
        end else begin
          unique case (funct)
            2'b00: word_c_o.aluop = ALU_SLL;
            2'b01: word_c_o.aluop = ALU_SRL;
            2'b10: word_c_o.aluop = ALU_MUL;
            2'b11: begin
              word_c_o    = BUBBLE;
              rd_a_c_o    = 1'b0;
              rd_b_c_o    = 1'b0;
              illegal_c_o = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_decoder.sv
// Registered control decoder between fetch and execute: ID/EX register with
// load-use stall, multi-cycle MUL occupancy and taken-branch flush.
// Ports: clk    rising-edge clock
//        reset  asynchronous active-high reset
//        bus    slave side of ctrl_pipe_decoder_if (fetch handshake, br_taken,
//               flush, ex_* control word)
module ctrl_pipe_decoder
  import ctrl_pipe_decoder_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               reset,
  ctrl_pipe_decoder_if.slave bus
);

  localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MUL_BUSY = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  ctrl_word_t       ex_q;

  ctrl_word_t dec_word_c;
  logic       dec_rd_a_c;
  logic       dec_rd_b_c;
  logic       dec_illegal_c;
  logic       flush_c;
  logic       hazard_c;
  logic       in_ready_c;
  logic       take_c;
  logic       is_mul_c;

  ctrl_pipe_decoder_decode u_decode (
    .instr_i     (bus.instr),
    .word_c_o    (dec_word_c),
    .rd_a_c_o    (dec_rd_a_c),
    .rd_b_c_o    (dec_rd_b_c),
    .illegal_c_o (dec_illegal_c)
  );

  // Taken branch resolving in EX kills the instruction being offered
  assign flush_c = ex_q.valid && ex_q.branch && bus.br_taken;

  // Offered instruction reads the register a load in EX is still fetching
  assign hazard_c = ex_q.valid && ex_q.memtoreg && bus.in_valid &&
                    ((dec_rd_a_c && (dec_word_c.rega == ex_q.wraddr)) ||
                     (dec_rd_b_c && (dec_word_c.regb == ex_q.wraddr)));

  always_comb begin
    in_ready_c = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_RUN:      in_ready_c = !flush_c && !hazard_c;
        ST_LU_STALL: in_ready_c = 1'b1;
        default:     in_ready_c = 1'b0;
      endcase
    end
  end

  assign take_c   = bus.in_valid && in_ready_c;
  assign is_mul_c = !dec_illegal_c && (dec_word_c.aluop == ALU_MUL) && (MUL_LAT > 1);

  // State, MUL occupancy counter and ID/EX register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      ex_q    <= BUBBLE;
    end else begin
      unique case (state_q)
        ST_MUL_BUSY: begin
          // ex_q holds the MUL; leave once the last extra cycle is counted
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= ST_RUN;
        end
        default: begin
          if (take_c) begin
            ex_q <= dec_illegal_c ? BUBBLE : dec_word_c;
            if (is_mul_c) begin
              state_q <= ST_MUL_BUSY;
              cnt_q   <= CNT_W'(MUL_LAT - 1);
            end else begin
              state_q <= ST_RUN;
            end
          end else begin
            ex_q    <= BUBBLE;
            state_q <= (state_q == ST_RUN && hazard_c && !flush_c) ? ST_LU_STALL : ST_RUN;
          end
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.flush       = flush_c;
  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_aluop    = ex_q.aluop;
  assign bus.ex_regwr    = ex_q.regwr;
  assign bus.ex_memwr    = ex_q.memwr;
  assign bus.ex_memtoreg = ex_q.memtoreg;
  assign bus.ex_alusrc   = ex_q.alusrc;
  assign bus.ex_memsrc   = ex_q.memsrc;
  assign bus.ex_branch   = ex_q.branch;
  assign bus.ex_rega     = ex_q.rega;
  assign bus.ex_regb     = ex_q.regb;
  assign bus.ex_wraddr   = ex_q.wraddr;
  assign bus.ex_immed    = ex_q.immed;

endmodule
